// File: rtl/fmv_ddr_arbiter.sv
// -----------------------------------------------------------------------------
// fmv_ddr_arbiter
//
// Shares the single DDR port between the FMV-side masters:
//   req 0 : frame player display fetch
//   req 1 : MPEG decoder frame writer
//   req 2 : reference-frame fetch
//
// Arbitration is round-robin. A grant is locked while the owner holds acquire,
// read or write, and while any of its read beats are still outstanding. This
// keeps a burst from being split across owners. There is always one idle cycle
// between two owners. Everything runs in the DDR clock domain.
//
// Optional feature (macro FMV_ARB_PRIORITY_EN):
//   defined     - requester 0 wins whenever it is active at arbitration time.
//                 The other requesters round-robin among themselves.
//   not defined - pure round-robin over all NUM_REQ requesters.
//   Neither mode pre-empts a current owner.
//
// Ports:
//   clk, reset_n        DDR clock and asynchronous active-low reset
//   req_read/write      per-requester command strobes, held until accepted
//   req_acquire         per-requester ownership request / lock
//   req_addr/burstcnt/wdata/byteenable  packed per-requester command fields
//   req_grant           one-hot current owner (0 when idle)
//   req_busy            ddr_busy for the owner, 1 for everyone else
//   req_rdata_ready     ddr_rdata_ready routed to the owner only
//   rdata               ddr_rdata broadcast to all requesters
//   ddr_*               command port toward the DDR controller
//   ddr_busy            DDR waitrequest
//   ddr_rdata_ready     DDR read data valid
//   ddr_rdata           DDR read data
// -----------------------------------------------------------------------------
module fmv_ddr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 29,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 8,
    parameter int OUTST_W = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_read,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ-1:0]         req_acquire,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*BURST_W-1:0] req_burstcnt,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    input  logic [NUM_REQ*8-1:0]       req_byteenable,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [NUM_REQ-1:0]         req_busy,
    output logic [NUM_REQ-1:0]         req_rdata_ready,
    output logic [DATA_W-1:0]          rdata,
    output logic                       ddr_read,
    output logic                       ddr_write,
    output logic [ADDR_W-1:0]          ddr_addr,
    output logic [BURST_W-1:0]         ddr_burstcnt,
    output logic [DATA_W-1:0]          ddr_wdata,
    output logic [7:0]                 ddr_byteenable,
    input  logic                       ddr_busy,
    input  logic                       ddr_rdata_ready,
    input  logic [DATA_W-1:0]          ddr_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OUTST_W-1:0] outst_q, outst_d;

    logic [NUM_REQ-1:0] active;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   pick;
    logic               pick_vld;
    logic               rd_accept;
    logic               release_ok;
    logic               underflow;
    logic [OUTST_W:0]   outst_sum;

    assign active = req_acquire | req_read | req_write;

    // -------------------------------------------------------------------------
    // Arbitration: first active index at or after rr_ptr, modulo NUM_REQ.
    // cand is one bit wider so rr_ptr + k never wraps before the modulo fold.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!pick_vld && active[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[IDX_W-1:0];
            end
        end
`ifdef FMV_ARB_PRIORITY_EN
        // Display fetch overrides the rotation so the frame player never starves.
        if (active[0]) begin
            pick_vld = 1'b1;
            pick     = '0;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Command mux and per-requester handshake routing. grant_q is zero when
    // idle, so nothing is forwarded and every requester sees busy.
    // -------------------------------------------------------------------------
    always_comb begin
        ddr_read        = 1'b0;
        ddr_write       = 1'b0;
        ddr_addr        = '0;
        ddr_burstcnt    = '0;
        ddr_wdata       = '0;
        ddr_byteenable  = '0;
        req_busy        = '1;
        req_rdata_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                ddr_read           = req_read[i];
                ddr_write          = req_write[i];
                ddr_addr           = req_addr[i*ADDR_W +: ADDR_W];
                ddr_burstcnt       = req_burstcnt[i*BURST_W +: BURST_W];
                ddr_wdata          = req_wdata[i*DATA_W +: DATA_W];
                ddr_byteenable     = req_byteenable[i*8 +: 8];
                req_busy[i]        = ddr_busy;
                req_rdata_ready[i] = ddr_rdata_ready;
            end
        end
    end

    assign req_grant = grant_q;
    assign rdata     = ddr_rdata;
    assign rd_accept = ddr_read & ~ddr_busy;

    // Ownership ends only once the owner is quiet and no beat is in flight.
    assign release_ok = !req_acquire[owner_q] && !req_read[owner_q] &&
                        !req_write[owner_q] && (outst_q == '0) && !ddr_rdata_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        outst_d   = outst_q;
        underflow = 1'b0;
        outst_sum = {1'b0, outst_q} + (rd_accept ? (OUTST_W+1)'(ddr_burstcnt) : '0);

        case (state_q)
            ST_IDLE: begin
                // Beats arriving with no owner are stray and are dropped.
                if (pick_vld) begin
                    state_d = ST_OWNED;
                    grant_d = NUM_REQ'(1) << pick;
                    owner_d = pick;
                end
            end
            ST_OWNED: begin
                // Net change of an accepted read and a returning beat in one cycle.
                if (ddr_rdata_ready && (outst_sum == '0)) begin
                    underflow = 1'b1;
                    outst_d   = '0;
                end else if (ddr_rdata_ready) begin
                    outst_d = OUTST_W'(outst_sum - 1'b1);
                end else begin
                    outst_d = outst_sum[OUTST_W-1:0];
                end

                if (release_ok) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            outst_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            outst_q  <= outst_d;
        end
    end

    // A beat returned while nothing is outstanding points at a broken master.
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !underflow);

endmodule

// File: tb/tb_fmv_ddr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fmv_ddr_arbiter
//
// Directed bench for fmv_ddr_arbiter. A behavioural model tracks the owner, the
// rotation pointer and the outstanding-beat count as plain integers. A compare
// process checks every DUT output against that model on each falling edge.
// Hand-computed literal checks pin grant order, beat counts and release timing.
// Build with +define+FMV_ARB_PRIORITY_EN to exercise the priority variant.
// -----------------------------------------------------------------------------
module tb_fmv_ddr_arbiter;

    localparam int NR      = 3;
    localparam int ADDR_W  = 29;
    localparam int DATA_W  = 64;
    localparam int BURST_W = 8;
    localparam int OUTST_W = 10;

    logic clk = 1'b0;
    logic reset_n;

    logic [NR-1:0]         a_read, a_write, a_acq;
    logic [ADDR_W-1:0]     a_addr  [NR];
    logic [BURST_W-1:0]    a_burst [NR];
    logic [DATA_W-1:0]     a_wdata [NR];
    logic [7:0]            a_be    [NR];

    logic [NR*ADDR_W-1:0]  req_addr;
    logic [NR*BURST_W-1:0] req_burstcnt;
    logic [NR*DATA_W-1:0]  req_wdata;
    logic [NR*8-1:0]       req_byteenable;

    logic [NR-1:0]         req_grant, req_busy, req_rdata_ready;
    logic [DATA_W-1:0]     rdata;
    logic                  ddr_read, ddr_write;
    logic [ADDR_W-1:0]     ddr_addr;
    logic [BURST_W-1:0]    ddr_burstcnt;
    logic [DATA_W-1:0]     ddr_wdata;
    logic [7:0]            ddr_byteenable;
    logic                  ddr_busy, ddr_rdata_ready;
    logic [DATA_W-1:0]     ddr_rdata;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_addr[g*ADDR_W +: ADDR_W]     = a_addr[g];
        assign req_burstcnt[g*BURST_W +: BURST_W] = a_burst[g];
        assign req_wdata[g*DATA_W +: DATA_W]     = a_wdata[g];
        assign req_byteenable[g*8 +: 8]         = a_be[g];
    end

    fmv_ddr_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .BURST_W (BURST_W),
        .OUTST_W (OUTST_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_read        (a_read),
        .req_write       (a_write),
        .req_acquire     (a_acq),
        .req_addr        (req_addr),
        .req_burstcnt    (req_burstcnt),
        .req_wdata       (req_wdata),
        .req_byteenable  (req_byteenable),
        .req_grant       (req_grant),
        .req_busy        (req_busy),
        .req_rdata_ready (req_rdata_ready),
        .rdata           (rdata),
        .ddr_read        (ddr_read),
        .ddr_write       (ddr_write),
        .ddr_addr        (ddr_addr),
        .ddr_burstcnt    (ddr_burstcnt),
        .ddr_wdata       (ddr_wdata),
        .ddr_byteenable  (ddr_byteenable),
        .ddr_busy        (ddr_busy),
        .ddr_rdata_ready (ddr_rdata_ready),
        .ddr_rdata       (ddr_rdata)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------ model
    int m_owner = -1;   // -1 means nobody owns the port
    int m_ptr   = 0;
    int m_outst = 0;

    function automatic int pick_next(input int ptr, input logic [NR-1:0] act);
`ifdef FMV_ARB_PRIORITY_EN
        if (act[0]) return 0;
`endif
        for (int k = 0; k < NR; k++) begin
            if (act[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model_p
        int nxt_owner;
        int nxt_ptr;
        int nxt_outst;
        if (!reset_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_outst <= 0;
        end else begin
            nxt_owner = m_owner;
            nxt_ptr   = m_ptr;
            nxt_outst = m_outst;
            if (m_owner < 0) begin
                nxt_owner = pick_next(m_ptr, a_acq | a_read | a_write);
            end else begin
                if (a_read[m_owner] && !ddr_busy) nxt_outst += int'(a_burst[m_owner]);
                if (ddr_rdata_ready) nxt_outst -= 1;
                if (nxt_outst < 0) nxt_outst = 0;
                if (!a_acq[m_owner] && !a_read[m_owner] && !a_write[m_owner] &&
                    m_outst == 0 && !ddr_rdata_ready) begin
                    nxt_owner = -1;
                    nxt_ptr   = (m_owner + 1) % NR;
                end
            end
            m_owner <= nxt_owner;
            m_ptr   <= nxt_ptr;
            m_outst <= nxt_outst;
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin : compare_p
        logic [NR-1:0] e_grant, e_busy, e_rdy;
        logic          e_rd, e_wr;
        logic [63:0]   e_addr, e_burst, e_wdata, e_be;
        e_grant = '0; e_busy = '1; e_rdy = '0;
        e_rd = 1'b0; e_wr = 1'b0;
        e_addr = '0; e_burst = '0; e_wdata = '0; e_be = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_busy[m_owner]  = ddr_busy;
            e_rdy[m_owner]   = ddr_rdata_ready;
            e_rd    = a_read[m_owner];
            e_wr    = a_write[m_owner];
            e_addr  = 64'(a_addr[m_owner]);
            e_burst = 64'(a_burst[m_owner]);
            e_wdata = 64'(a_wdata[m_owner]);
            e_be    = 64'(a_be[m_owner]);
        end
        check("req_grant", 64'(req_grant), 64'(e_grant));
        check("req_busy", 64'(req_busy), 64'(e_busy));
        check("req_rdata_ready", 64'(req_rdata_ready), 64'(e_rdy));
        check("ddr_read", 64'(ddr_read), 64'(e_rd));
        check("ddr_write", 64'(ddr_write), 64'(e_wr));
        check("ddr_addr", 64'(ddr_addr), e_addr);
        check("ddr_burstcnt", 64'(ddr_burstcnt), e_burst);
        check("ddr_wdata", 64'(ddr_wdata), e_wdata);
        check("ddr_byteenable", 64'(ddr_byteenable), e_be);
        check("rdata", 64'(rdata), 64'(ddr_rdata));
    end

    // Observed event counters used by the literal checks.
    int rd_cycles = 0;
    int rdy_cnt [NR];
    initial for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;

    always @(negedge clk) begin
        if (ddr_read) rd_cycles++;
        for (int i = 0; i < NR; i++) if (req_rdata_ready[i]) rdy_cnt[i]++;
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat();
        ddr_rdata_ready = 1'b1;
        ddr_rdata       = {$urandom, $urandom};
        tick();
        ddr_rdata_ready = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int rd0, r0, r1, r2, o, prev;
        int exp_own [4];
        logic [NR-1:0] eg;

        reset_n = 1'b0;
        a_read = '0; a_write = '0; a_acq = '0;
        for (int i = 0; i < NR; i++) begin
            a_addr[i] = '0; a_burst[i] = '0; a_wdata[i] = '0; a_be[i] = '0;
        end
        ddr_busy = 1'b0; ddr_rdata_ready = 1'b0; ddr_rdata = '0;

        // Reset state
        tick(2);
        check("reset grant", 64'(req_grant), 64'h0);
        check("reset busy", 64'(req_busy), 64'h7);
        check("reset ddr_read", 64'(ddr_read), 64'h0);
        check("reset ddr_write", 64'(ddr_write), 64'h0);
        reset_n = 1'b1;
        tick();

        // Single requester: req1 reads a 25-beat burst
        rd0 = rd_cycles;
        a_acq[1] = 1'b1; a_read[1] = 1'b1;
        a_addr[1] = 29'h123_4567; a_burst[1] = 8'd25; a_be[1] = 8'hff;
        tick();
        check("single grant after 1 cycle", 64'(req_grant), 64'h2);
        tick();
        a_read[1] = 1'b0;
        r1 = rdy_cnt[1];
        repeat (25) beat();
        tick(2);
        check("single beats to req1", 64'(rdy_cnt[1] - r1), 64'd25);
        check("single ddr_read cycles", 64'(rd_cycles - rd0), 64'd1);
        check("single held by acquire", 64'(req_grant), 64'h2);
        a_acq[1] = 1'b0;
        tick();
        check("single release", 64'(req_grant), 64'h0);

        // Contention: all three raise acquire together, each owns 4 cycles
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
`ifdef FMV_ARB_PRIORITY_EN
        exp_own = '{0, 1, 0, 1};
`else
        exp_own = '{0, 1, 2, 0};
`endif
        a_acq = '1;
        prev = -1;
        for (int s = 0; s < 4; s++) begin
            tick();
            eg = '0;
            eg[exp_own[s]] = 1'b1;
            check("contend grant order", 64'(req_grant), 64'(eg));
            if (prev >= 0) a_acq[prev] = 1'b1;
            o = exp_own[s];
            a_write[o] = 1'b1;
            a_addr[o]  = ADDR_W'(32'h100 * (s + 1));
            a_wdata[o] = {$urandom, $urandom};
            a_be[o]    = 8'h0f << s;
            tick();
            a_write[o] = 1'b0;
            tick(3);
            a_acq[o] = 1'b0;
            if (s == 3) a_acq = '0;
            tick();
            check("contend idle gap", 64'(req_grant), 64'h0);
            prev = o;
        end

        // Early acquire drop: req2 reads 50 beats spaced 2 cycles apart
        a_acq[2] = 1'b1; a_read[2] = 1'b1;
        a_addr[2] = 29'h0ab_cdef; a_burst[2] = 8'd50; a_be[2] = 8'hff;
        tick();
        check("drop grant", 64'(req_grant), 64'h4);
        tick();
        a_acq[2] = 1'b0; a_read[2] = 1'b0;
        r2 = rdy_cnt[2];
        for (int b = 0; b < 50; b++) begin
            beat();
            tick();
            if (b == 48) check("drop held before last beat", 64'(req_grant), 64'h4);
        end
        check("drop beats to req2", 64'(rdy_cnt[2] - r2), 64'd50);
        check("drop released after last beat", 64'(req_grant), 64'h0);

        // Busy stall: req0 reads under waitrequest while req1 holds a write
        ddr_busy = 1'b1;
        a_acq[0] = 1'b1; a_read[0] = 1'b1;
        a_addr[0] = 29'h000_0a00; a_burst[0] = 8'd4; a_be[0] = 8'hff;
        a_acq[1] = 1'b1; a_write[1] = 1'b1;
        a_addr[1] = 29'h1f0_0000; a_wdata[1] = 64'hdead_beef_cafe_f00d; a_be[1] = 8'h3c;
        tick();
        check("stall grant", 64'(req_grant), 64'h1);
        for (int c = 0; c < 5; c++) begin
            check("stall ddr_read held", 64'(ddr_read), 64'h1);
            check("stall addr is owner", 64'(ddr_addr), 64'h0a00);
            check("stall non-owner busy", 64'(req_busy[1]), 64'h1);
            tick();
        end
        ddr_busy = 1'b0;
        tick();
        a_read[0] = 1'b0;
        repeat (4) beat();
        check("stall still owned", 64'(req_grant), 64'h1);
        check("stall non-owner busy after", 64'(req_busy[1]), 64'h1);
        a_acq[0] = 1'b0;
        tick();
        check("stall release", 64'(req_grant), 64'h0);
        tick();
        check("stall next owner", 64'(req_grant), 64'h2);
        check("stall writer wdata", 64'(ddr_wdata), 64'hdead_beef_cafe_f00d);
        tick();
        a_write[1] = 1'b0; a_acq[1] = 1'b0;
        tick();
        check("stall writer release", 64'(req_grant), 64'h0);

        // Reset mid-burst: 10 of 25 beats, then reset with a read pending
        a_acq[1] = 1'b1; a_read[1] = 1'b1; a_burst[1] = 8'd25;
        tick();
        check("rst grant", 64'(req_grant), 64'h2);
        tick();
        a_read[1] = 1'b0;
        repeat (10) beat();
        ddr_busy = 1'b1; a_read[1] = 1'b1;
        tick();
        check("rst read pending", 64'(ddr_read), 64'h1);
        reset_n = 1'b0;
        #1;
        check("rst grant cleared", 64'(req_grant), 64'h0);
        check("rst ddr_read cleared", 64'(ddr_read), 64'h0);
        a_acq = '0; a_read = '0; ddr_busy = 1'b0;
        tick();
        reset_n = 1'b1;
        r0 = rdy_cnt[0]; r1 = rdy_cnt[1]; r2 = rdy_cnt[2];
        repeat (15) beat();
        tick();
        check("rst late beats req0", 64'(rdy_cnt[0] - r0), 64'd0);
        check("rst late beats req1", 64'(rdy_cnt[1] - r1), 64'd0);
        check("rst late beats req2", 64'(rdy_cnt[2] - r2), 64'd0);
        check("rst stays idle", 64'(req_grant), 64'h0);

        // Priority / wrap: req2 owns with req0, req1 waiting
        a_acq[2] = 1'b1;
        tick();
        check("prio req2 owns", 64'(req_grant), 64'h4);
        a_acq[0] = 1'b1; a_acq[1] = 1'b1;
        tick(2);
        a_acq[2] = 1'b0;
        tick();
        check("prio gap 1", 64'(req_grant), 64'h0);
        tick();
        check("prio after req2", 64'(req_grant), 64'h1);
        a_acq[0] = 1'b0;
        tick(2);
        check("prio req1 owns", 64'(req_grant), 64'h2);
        a_acq[0] = 1'b1; a_acq[2] = 1'b1;
        tick();
        a_acq[1] = 1'b0;
        tick();
        check("prio gap 2", 64'(req_grant), 64'h0);
        tick();
`ifdef FMV_ARB_PRIORITY_EN
        check("prio after req1", 64'(req_grant), 64'h1);
`else
        check("prio after req1", 64'(req_grant), 64'h4);
`endif
        a_acq = '0;
        tick();
        check("final idle", 64'(req_grant), 64'h0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fmv_ddr_arbiter.md
Name: fmv_ddr_arbiter

Overview:
- Shares the single DDR port between FMV-side masters: frame player display fetch (req 0), MPEG decoder frame writer (req 1) and reference-frame fetch (req 2).
- Grants are round-robin. Each grant is locked by the requester's acquire flag plus its outstanding read beats, so a burst is never split across owners.
- Sits between the FMV masters and the top-level DDR interface. One clock domain, which is the DDR clock.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 29, DDR word address width.
- DATA_W, 64, DDR data width.
- BURST_W, 8, burst count width.
- OUTST_W, 10, outstanding-beat counter width.

Ports:
- clk  in  1  DDR clock.
- reset_n  in  1  asynchronous active-low reset.
- req_read  in  NUM_REQ  per-requester read strobe, held until accepted.
- req_write  in  NUM_REQ  per-requester write strobe, held until accepted.
- req_acquire  in  NUM_REQ  per-requester ownership request/lock.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses.
- req_burstcnt  in  NUM_REQ*BURST_W  packed burst counts.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_byteenable  in  NUM_REQ*8  packed byte enables.
- req_grant  out  NUM_REQ  one-hot current owner.
- req_busy  out  NUM_REQ  per-requester busy: ddr_busy for the owner, 1 for all others.
- req_rdata_ready  out  NUM_REQ  ddr_rdata_ready routed to the owner only.
- rdata  out  DATA_W  ddr_rdata passthrough, shared by all requesters.
- ddr_read, ddr_write  out  1  DDR command strobes.
- ddr_addr  out  ADDR_W  DDR address.
- ddr_burstcnt  out  BURST_W  DDR burst count.
- ddr_wdata  out  DATA_W  DDR write data.
- ddr_byteenable  out  8  DDR byte enables.
- ddr_busy  in  1  DDR waitrequest.
- ddr_rdata_ready  in  1  DDR read data valid.
- ddr_rdata  in  DATA_W  DDR read data.

Behaviour:
- Reset (async assert, sync release):
  - req_grant=0, state=IDLE, rr_ptr=0, outstanding=0.
  - All ddr_* command outputs 0; req_busy all 1.
- States: IDLE, OWNED.
- Active request: active[i] = req_acquire[i] | req_read[i] | req_write[i].
- IDLE, no active request: stay in IDLE.
- IDLE, any active request:
  - Select the first active index at or after rr_ptr, searching modulo NUM_REQ.
  - Register the one-hot grant and move to OWNED.
  - Latency is 1 cycle from request to req_grant.
- OWNED, command mux:
  - ddr_read/write/addr/burstcnt/wdata/byteenable are driven combinationally from the owner's inputs.
  - With no owner (IDLE), ddr_read and ddr_write are 0 and the remaining ddr_* outputs are 0.
- Command acceptance: a read or write is accepted when it is asserted and ddr_busy=0.
- Outstanding-beat counter:
  - On an accepted read, add the owner's burstcnt.
  - On each ddr_rdata_ready, subtract 1.
  - If both happen in the same cycle, apply the net change (burstcnt-1).
  - Underflow saturates at 0 and fires a simulation assertion.
- Release condition, evaluated in OWNED:
  - owner acquire=0, read=0 and write=0;
  - outstanding=0;
  - no ddr_rdata_ready in the current cycle.
  - When met, go to IDLE, clear grant and set rr_ptr=owner+1 (mod NUM_REQ).
  - Re-arbitration happens the following cycle, so there is a mandatory one-cycle gap between owners.
- Commands from non-owners are ignored; their req_busy stays 1, so they hold their strobes.
- A requester that drops acquire mid-burst keeps ownership until its read beats drain.
- Reset asserted mid-burst: grant and counter clear immediately. Late rdata_ready beats after release are ignored and reach no requester.
- rdata is broadcast; consumers qualify it with their own req_rdata_ready.

Optional Feature:
- Macro FMV_ARB_PRIORITY_EN.
- Defined: requester 0 has strict priority in IDLE. It is granted whenever active, regardless of rr_ptr; the others round-robin among themselves. This protects display fetch from underrun.
- Not defined: pure round-robin over all NUM_REQ requesters.
- Neither mode pre-empts an owner.

Test Plan:
- Single requester: req1 acquire+read, burstcnt=25, ddr_busy low → grant=3'b010 after 1 cycle; ddr_read for 1 cycle; exactly 25 req_rdata_ready[1] pulses; release once acquire drops and the counter reaches 0.
- Contention: all three raise acquire at the same cycle, each owner holds for 4 cycles → grant order 001, 010, 100, 001 with a 1-cycle IDLE gap between owners.
- Early acquire drop: owner drops acquire after the read is accepted with burstcnt=50, beats spaced 2 cycles → grant held until the 50th beat, then released.
- Busy stall: ddr_busy high 5 cycles during an owner read → ddr_read held, counter unchanged until acceptance; the non-owner's req_busy stays 1 throughout.
- Reset mid-burst: reset_n low after 10 of 25 beats → grant=0, ddr_read=0 immediately; the remaining beats produce no req_rdata_ready.
- FMV_ARB_PRIORITY_EN defined: req2 owns, req0 and req1 waiting → next grant is req0. Undefined: next grant is req0 (rr_ptr wraps from 2 to 0). Then with req1 owning and req0 and req2 waiting: defined → req0, undefined → req2.
